// File: rtl/exm_div_pkg.sv
// Shared types and constants for the execute/memory-stage divide sequencer.
// Latency constants describe the default 32-bit configuration.
package exm_div_pkg;

    localparam int XLEN_DEF  = 32;
    localparam int DIV_ITERS = XLEN_DEF;
    localparam int DIV_LAT   = DIV_ITERS + 3;
    localparam logic [XLEN_DEF-1:0] DIV0_QUO = {XLEN_DEF{1'b1}};

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_PREP = 3'd1,
        ST_CALC = 3'd2,
        ST_FIX  = 3'd3,
        ST_DONE = 3'd4
    } div_state_e;

endpackage

// File: rtl/div_restore_step.sv
// One combinational radix-2 restoring iteration on the {rem, quo} pair.
// The trial subtract is one bit wider so its MSB is the borrow/sign.
module div_restore_step #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] rem_i,
    input  logic [XLEN-1:0] quo_i,
    input  logic [XLEN-1:0] div_i,
    output logic [XLEN-1:0] rem_o,
    output logic [XLEN-1:0] quo_o
);

    logic [XLEN:0] rem_sh_s;
    logic [XLEN:0] trial_s;

    // Shift, trial subtract, restore on borrow.
    always_comb begin
        rem_sh_s = {rem_i, quo_i[XLEN-1]};
        trial_s  = rem_sh_s - {1'b0, div_i};
        if (!trial_s[XLEN]) begin
            rem_o = trial_s[XLEN-1:0];
        end else begin
            rem_o = rem_sh_s[XLEN-1:0];
        end
        quo_o = {quo_i[XLEN-2:0], ~trial_s[XLEN]};
    end

endmodule

// File: rtl/exm_div_sequencer.sv
// Multi-cycle signed/unsigned restoring divider: accept, prepare magnitudes,
// iterate XLEN times, apply sign fixup, hold result until consumed.
module exm_div_sequencer
    import exm_div_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter int CNT_W = 6
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start_valid,
    output logic            start_ready,
    input  logic            is_unsigned,
    input  logic            use_mod,
    input  logic [XLEN-1:0] src1,
    input  logic [XLEN-1:0] src2,
    input  logic            flush,
    output logic            busy,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(XLEN - 1);
    localparam logic [XLEN-1:0]  DIV0_RES = {XLEN{1'b1}};

    div_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [XLEN-1:0]  src1_q, src1_d, src2_q, src2_d;
    logic [XLEN-1:0]  rem_q, rem_d, quo_q, quo_d;
    logic [XLEN-1:0]  result_q, result_d;
    logic             uns_q, uns_d, mod_q, mod_d;
    logic             q_neg_q, q_neg_d, r_neg_q, r_neg_d;

    logic             a_neg_s, b_neg_s;
    logic [XLEN-1:0]  a_mag_s, b_mag_s;
    logic [XLEN-1:0]  step_rem_s, step_quo_s;

    div_restore_step #(.XLEN(XLEN)) u_step (
        .rem_i (rem_q),
        .quo_i (quo_q),
        .div_i (src2_q),
        .rem_o (step_rem_s),
        .quo_o (step_quo_s)
    );

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            src1_q   <= '0;
            src2_q   <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            result_q <= '0;
            uns_q    <= 1'b0;
            mod_q    <= 1'b0;
            q_neg_q  <= 1'b0;
            r_neg_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            src1_q   <= src1_d;
            src2_q   <= src2_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            result_q <= result_d;
            uns_q    <= uns_d;
            mod_q    <= mod_d;
            q_neg_q  <= q_neg_d;
            r_neg_q  <= r_neg_d;
        end
    end

    // Next-state and datapath update; src2_q is reused to hold |divisor| after PREP.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        src1_d   = src1_q;
        src2_d   = src2_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        result_d = result_q;
        uns_d    = uns_q;
        mod_d    = mod_q;
        q_neg_d  = q_neg_q;
        r_neg_d  = r_neg_q;

        a_neg_s = !uns_q && src1_q[XLEN-1];
        b_neg_s = !uns_q && src2_q[XLEN-1];
        a_mag_s = a_neg_s ? -src1_q : src1_q;
        b_mag_s = b_neg_s ? -src2_q : src2_q;

        case (state_q)
            ST_IDLE: begin
                if (start_valid && !flush) begin
                    src1_d  = src1;
                    src2_d  = src2;
                    uns_d   = is_unsigned;
                    mod_d   = use_mod;
                    state_d = ST_PREP;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_PREP: begin
                q_neg_d = a_neg_s ^ b_neg_s;
                r_neg_d = a_neg_s;
                if (b_mag_s == '0) begin
                    result_d = mod_q ? src1_q : DIV0_RES;
                    state_d  = ST_DONE;
                end else begin
                    rem_d   = '0;
                    quo_d   = a_mag_s;
                    src2_d  = b_mag_s;
                    cnt_d   = '0;
                    state_d = ST_CALC;
                end
            end
            ST_CALC: begin
                rem_d = step_rem_s;
                quo_d = step_quo_s;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_CNT) begin
                    state_d = ST_FIX;
                end else begin
                    state_d = ST_CALC;
                end
            end
            ST_FIX: begin
                if (mod_q) begin
                    result_d = r_neg_q ? -rem_q : rem_q;
                end else begin
                    result_d = q_neg_q ? -quo_q : quo_q;
                end
                state_d = ST_DONE;
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (flush) begin
            state_d = ST_IDLE;
        end else begin
            state_d = state_d;
        end
    end

    assign start_ready = (state_q == ST_IDLE);
    assign busy        = (state_q != ST_IDLE);
    assign out_valid   = (state_q == ST_DONE);
    assign result      = result_q;

endmodule

// File: tb/tb_exm_div_sequencer.sv
// Self-checking bench for exm_div_sequencer: directed corner cases plus
// randomized divides compared against a plain-arithmetic reference.
module tb_exm_div_sequencer;
    import exm_div_pkg::*;

    logic        clk = 1'b0;
    logic        reset, start_valid, start_ready, is_unsigned, use_mod;
    logic [31:0] src1, src2, result;
    logic        flush, busy, out_valid, out_ready;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    exm_div_sequencer #(.XLEN(32), .CNT_W(6)) dut (
        .clk         (clk),
        .reset       (reset),
        .start_valid (start_valid),
        .start_ready (start_ready),
        .is_unsigned (is_unsigned),
        .use_mod     (use_mod),
        .src1        (src1),
        .src2        (src2),
        .flush       (flush),
        .busy        (busy),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .result      (result)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Reference: integer division rules, truncating toward zero.
    function automatic logic [31:0] ref_div(input logic [31:0] a, input logic [31:0] b,
                                            input bit uns, input bit md);
        int sa;
        int sb;
        sa = signed'(a);
        sb = signed'(b);
        if (b == 32'd0) return md ? a : DIV0_QUO;
        if (uns) return md ? (a % b) : (a / b);
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return md ? 32'd0 : a;
        return md ? 32'(sa % sb) : 32'(sa / sb);
    endfunction

    // Present a request at a negedge; returns at the negedge after the accept edge.
    task automatic issue(input logic [31:0] a, input logic [31:0] b, input bit uns, input bit md);
        start_valid = 1'b1;
        src1 = a;
        src2 = b;
        is_unsigned = uns;
        use_mod = md;
        @(negedge clk);
        start_valid = 1'b0;
        src1 = $urandom;
        src2 = $urandom;
        is_unsigned = ~uns;
        use_mod = ~md;
    endtask

    task automatic wait_done(input int exp_lat, input logic [31:0] exp_res, input string tag);
        int n;
        n = 1;
        while (!out_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        check_val({tag, "_lat"}, 32'(n), 32'(exp_lat));
        check_val({tag, "_res"}, result, exp_res);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check_val({tag, "_idle"}, {30'd0, busy, out_valid}, 32'd0);
    endtask

    task automatic run_div(input logic [31:0] a, input logic [31:0] b, input bit uns,
                           input bit md, input string tag);
        issue(a, b, uns, md);
        wait_done((b == 32'd0) ? 2 : DIV_LAT, ref_div(a, b, uns, md), tag);
    endtask

    initial begin
        logic [31:0] a, b;
        logic [31:0] held;
        int n;
        reset = 1'b1;
        start_valid = 1'b0;
        is_unsigned = 1'b0;
        use_mod = 1'b0;
        src1 = 32'd0;
        src2 = 32'd0;
        flush = 1'b0;
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check_val("rst_state", {28'd0, start_ready, busy, out_valid, 1'b0}, 32'h8);
        check_val("rst_result", result, 32'd0);

        // Directed cases
        issue(32'd100, 32'd7, 1'b1, 1'b0);
        check_val("busy_rise", {30'd0, busy, start_ready}, 32'd2);
        wait_done(DIV_LAT, 32'd14, "u100div7");
        run_div(32'd100, 32'd7, 1'b1, 1'b1, "u100mod7");
        run_div(32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0, "sm7div2");
        run_div(32'hFFFF_FFF9, 32'd2, 1'b0, 1'b1, "sm7mod2");
        run_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, "ovf_quo");
        run_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b1, "ovf_rem");
        run_div(32'h1234, 32'd0, 1'b0, 1'b0, "div0_quo");
        run_div(32'h1234, 32'd0, 1'b1, 1'b1, "div0_rem");

        // Flush in CALC at iteration 10
        issue(32'd1000, 32'd7, 1'b1, 1'b0);
        repeat (11) @(negedge clk);
        check_val("pre_flush_busy", {31'd0, busy}, 32'd1);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check_val("flush_idle", {29'd0, start_ready, busy, out_valid}, 32'd4);
        repeat (40) begin
            @(negedge clk);
            if (out_valid) check_val("flush_no_valid", {31'd0, out_valid}, 32'd0);
        end
        run_div(32'd9, 32'd3, 1'b1, 1'b0, "after_flush");

        // Start and flush together in IDLE
        start_valid = 1'b1;
        flush = 1'b1;
        src1 = 32'd50;
        src2 = 32'd5;
        @(negedge clk);
        start_valid = 1'b0;
        flush = 1'b0;
        check_val("sv_flush_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        check_val("sv_flush_busy2", {31'd0, busy}, 32'd0);

        // Hold in DONE with out_ready low and start_valid pending
        issue(32'd100, 32'd7, 1'b1, 1'b0);
        n = 1;
        while (!out_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        check_val("hold_lat", 32'(n), 32'(DIV_LAT));
        held = result;
        start_valid = 1'b1;
        src1 = 32'd9;
        src2 = 32'd3;
        is_unsigned = 1'b1;
        use_mod = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check_val("hold_valid", {30'd0, out_valid, start_ready}, 32'd2);
            check_val("hold_result", result, held);
            @(negedge clk);
        end
        check_val("hold_val14", held, 32'd14);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check_val("consume_idle", {29'd0, start_ready, busy, out_valid}, 32'd4);
        @(negedge clk);
        start_valid = 1'b0;
        check_val("next_accept", {30'd0, busy, start_ready}, 32'd2);
        wait_done(DIV_LAT, 32'd3, "b2b_9div3");

        // Reset in CALC
        issue(32'hDEAD_BEEF, 32'd17, 1'b1, 1'b1);
        repeat (6) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_val("rst_mid_state", {29'd0, start_ready, busy, out_valid}, 32'd4);
        check_val("rst_mid_result", result, 32'd0);
        run_div(32'd77, 32'd10, 1'b1, 1'b1, "after_rst");

        // Randomized operations
        for (int i = 0; i < 40; i++) begin
            a = $urandom;
            if ($urandom_range(0, 3) == 0) a = a >> $urandom_range(0, 31);
            case ($urandom_range(0, 5))
                0:       b = 32'd0;
                1:       b = 32'($urandom_range(1, 15));
                2:       b = -32'($urandom_range(1, 15));
                default: b = 32'($urandom) >> $urandom_range(0, 31);
            endcase
            run_div(a, b, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), "rand");
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/exm_div_sequencer.md
# exm_div_sequencer

Multi-cycle signed/unsigned 32-bit divide sequencer for the execute/memory stage. It replaces the single-cycle divide path with a radix-2 restoring iteration. The block accepts one operation through a valid/ready handshake and sequences the operand preparation, iteration and sign-fixup phases. It holds the quotient or remainder until the stage consumes it, and aborts cleanly on a pipeline flush. The stage stalls its ready on `busy` while an operation is in flight.

## Interface
- `XLEN`, default 32: operand and result width.
- `CNT_W`, default 6: iteration counter width; must satisfy 2^CNT_W > XLEN.

Ports:
- `clk`: input, 1 bit. Clock.
- `reset`: input, 1 bit. Synchronous, active-high reset.
- `start_valid`: input, 1 bit. Divide request presented by the stage.
- `start_ready`: output, 1 bit. High only in IDLE.
- `is_unsigned`: input, 1 bit. 1 selects unsigned divide; 0 selects signed. Sampled on accept.
- `use_mod`: input, 1 bit. 1 returns the remainder; 0 returns the quotient. Sampled on accept.
- `src1`: input, XLEN bits. Dividend, sampled on accept.
- `src2`: input, XLEN bits. Divisor, sampled on accept.
- `flush`: input, 1 bit. Abort the current operation (branch mispredict or exception flush).
- `busy`: output, 1 bit. High in every state except IDLE.
- `out_valid`: output, 1 bit. Result available; high in DONE.
- `out_ready`: input, 1 bit. Stage consumes the result.
- `result`: output, XLEN bits. Quotient or remainder, stable while `out_valid` is high.

## Operation
- **States:** IDLE, PREP, CALC, FIX, DONE.
- **Reset:** state = IDLE, counter = 0, result = 0, out_valid = 0, busy = 0, start_ready = 1.
- **IDLE:** `start_valid && start_ready && !flush` latches the operands, `is_unsigned` and `use_mod`, then moves to PREP.
- **PREP:**
  - Computes the magnitudes |src1| and |src2|; in unsigned mode the operands pass through raw.
  - Records q_neg = sign1 ^ sign2 and r_neg = sign1; both are 0 in unsigned mode.
  - Divisor == 0: result = `use_mod` ? src1 : all-ones, then go to DONE and skip CALC/FIX.
  - Otherwise clear the partial remainder, load the quotient register with |src1|, set counter = 0, and go to CALC.
- **CALC:**
  - Each cycle performs one restoring step on the {rem, quo} pair:
    - shift the pair left by 1;
    - trial = rem − divisor (XLEN+1 bits);
    - if trial is non-negative, rem = trial and the quotient LSB = 1; otherwise the quotient LSB = 0.
  - The counter increments each cycle; after the step with counter == XLEN−1, go to FIX.
- **FIX:** result = `use_mod` ? (r_neg ? −rem : rem) : (q_neg ? −quo : quo). Then go to DONE.
- **DONE:** `out_valid` = 1. When `out_valid && out_ready`, go to IDLE. A new start cannot be accepted in the same cycle, so back-to-back divides have one bubble.
- **Signed overflow:** 0x80000000 / 0xFFFFFFFF needs no special case. It yields quotient 0x80000000 and remainder 0, because the magnitude math wraps.
- **Flush:**
  - In any non-IDLE state, `flush` forces IDLE on the next edge, drops `out_valid`, and discards the result.
  - In IDLE, `flush` takes priority over `start_valid` and the request is not accepted.
- **Reset mid-operation:** behaves identically to flush, and additionally clears all registers.

## Timing
- Call the accept edge edge 1.
- **Normal operation:** PREP after edge 1, CALC after edges 2–33 (32 iterations), FIX after edge 34, and `out_valid` high after edge 35. Fixed latency is 35 cycles.
- **Divide by zero:** `out_valid` is high after edge 2.
- `busy` rises at edge 1 and falls on the edge that consumes the result or applies the flush.
- `out_valid` holds until it is consumed, and `result` does not change while it is held.
- All outputs are registered; `start_ready` and `busy` are decoded directly from the state register.

## Structure
- **Package `exm_div_pkg`:**
  - state enum: IDLE/PREP/CALC/FIX/DONE
  - `DIV_ITERS = XLEN`
  - `DIV_LAT = DIV_ITERS + 3`
  - `DIV0_QUO = all-ones`
- **Sub-module `div_restore_step`:** combinational single iteration taking (rem, quo, divisor) and producing (rem', quo'). It is instantiated once and registered by the sequencer.

## Test plan
- Unsigned: 100 / 7 with `use_mod=0` → result 14 after exactly 35 cycles; with `use_mod=1` → 2.
- Signed: −7 / 2 → quotient 0xFFFFFFFD (−3), remainder 0xFFFFFFFF (−1). Signed: 0x80000000 / 0xFFFFFFFF → quotient 0x80000000, remainder 0.
- Divide by zero: src1 = 0x1234, src2 = 0 → quotient 0xFFFFFFFF and remainder 0x1234, with `out_valid` 2 cycles after accept.
- `flush` asserted in CALC at iteration 10 → next cycle IDLE, busy = 0, no `out_valid`. A following 9 / 3 request returns 3 correctly.
- `out_ready` held low for 5 cycles in DONE → result stable and `out_valid` held; `start_valid` is ignored until IDLE, and the next accept happens exactly one cycle after the consume.
- `start_valid` and `flush` asserted together in IDLE → not accepted, `busy` stays 0. Reset asserted in CALC → all outputs return to their reset values on the next edge.
